// File: rtl/mem_port_arbiter_if.sv
// Bundles the core, debug and memory-macro signals of the shared memory port.
// slave: the arbiter's view; master: the surrounding core/debug/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ack;
  logic              core_wait;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic              dbg_hold;

  logic [DATA_W-1:0] rd_data;
  logic              busy;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_hold,
    input  mem_rdata,
    output core_ack, core_wait, dbg_ack, rd_data, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_hold,
    output mem_rdata,
    input  core_ack, core_wait, dbg_ack, rd_data, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Core/debug arbiter for a single-port memory: one transaction at a time, IDLE->ISSUE->WAIT->ACK.
// Round-robin on ties; define ARB_FIXED_PRIO_EN to make debug always win ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_owner_dbg;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_core_ack;
  logic              r_dbg_ack;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rd_data;
`ifndef ARB_FIXED_PRIO_EN
  logic              r_last_dbg;
`endif

  logic              w_core_elig;
  logic              w_dbg_elig;
  logic              w_grant;
  logic              w_pick_dbg;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_core_elig = bus.core_req & ~bus.dbg_hold;
  assign w_dbg_elig  = bus.dbg_req;
  assign w_grant     = w_core_elig | w_dbg_elig;

`ifdef ARB_FIXED_PRIO_EN
  assign w_pick_dbg = w_dbg_elig;
`else
  // On a tie, debug wins only if the core was served last.
  assign w_pick_dbg = w_dbg_elig & (~w_core_elig | ~r_last_dbg);
`endif

  assign w_we    = w_pick_dbg ? bus.dbg_we    : bus.core_we;
  assign w_addr  = w_pick_dbg ? bus.dbg_addr  : bus.core_addr;
  assign w_wdata = w_pick_dbg ? bus.dbg_wdata : bus.core_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner_dbg <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_core_ack  <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_dbg  <= 1'b1;
`endif
    end else begin
      r_core_ack <= 1'b0;
      r_dbg_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner_dbg <= w_pick_dbg;
            r_we        <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_mem_we    <= w_we;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= CNT_W'(MEM_LAT);
          r_state  <= WAIT;
        end
        WAIT: begin
          // Last WAIT cycle is the one where mem_rdata is valid.
          if (r_cnt == CNT_W'(1)) begin
            if (!r_we) begin
              r_rd_data <= bus.mem_rdata;
            end
            r_core_ack <= ~r_owner_dbg;
            r_dbg_ack  <= r_owner_dbg;
            r_state    <= ACK;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ACK: begin
`ifndef ARB_FIXED_PRIO_EN
          r_last_dbg <= r_owner_dbg;
`endif
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.core_ack  = r_core_ack;
  assign bus.dbg_ack   = r_dbg_ack;
  assign bus.core_wait = bus.core_req & ~r_core_ack;
  assign bus.busy      = r_busy;
  assign bus.rd_data   = r_rd_data;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
